// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, result written WIDTH+1 edges after start.
// Optional macro SIGNED_DIV_EN selects two's-complement operands; default build is unsigned.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Partial remainder stays below M, so the top bit of A is always zero and is not stored.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             qs_q, qs_d;
  logic             ds_q, ds_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   a_sh, trial;

`ifdef SIGNED_DIV_EN
  assign dvd_neg = dividend_i[WIDTH-1];
  assign dvs_neg = divisor_i[WIDTH-1];
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif

  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;

  assign a_sh  = {a_q, q_q[WIDTH-1]};
  assign trial = a_sh - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    dvd_d   = dvd_q;
    qs_d    = qs_q;
    ds_d    = ds_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (start_i) begin
      // A start in any state aborts whatever is in flight and reloads.
      state_d = S_RUN;
      cnt_d   = '0;
      a_d     = '0;
      q_d     = dvd_mag;
      m_d     = dvs_mag;
      dvd_d   = dividend_i;
      qs_d    = dvd_neg ^ dvs_neg;
      ds_d    = dvd_neg;
      zero_d  = (divisor_i == '0);
    end else begin
      case (state_q)
        S_RUN: begin
          cnt_d = cnt_q + CW'(1);
          if (!trial[WIDTH]) begin
            a_d = trial[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            a_d = a_sh[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == LAST) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          if (zero_q) begin
            quot_d = '1;
            rem_d  = dvd_q;
            dz_d   = 1'b1;
          end else begin
            quot_d = qs_q ? -q_q : q_q;
            rem_d  = ds_q ? -a_q : a_q;
            dz_d   = 1'b0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      dvd_q   <= '0;
      qs_q    <= 1'b0;
      ds_q    <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      dvd_q   <= dvd_d;
      qs_q    <= qs_d;
      ds_q    <= ds_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;
  assign busy_o = (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o = (state_q == S_DONE);

endmodule
